// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring 32-bit signed/unsigned divider with flush annul
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_W);

    typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

    state_t              state, next;
    logic [CW-1:0]       cnt;
    logic [2*DATA_W:0]   work;
    logic [DATA_W-1:0]   dvs;
    logic                neg_q, neg_r;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   mag1, mag2, quo, rem;
    logic                take, leave;

    // A request counts only when not flushed in the same cycle
    assign take  = start_i && !annul_i;
    assign leave = !start_i || annul_i;

    // Magnitudes of the operands; the most negative value maps onto itself, which is correct as unsigned
    assign mag1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign mag2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    // Trial subtraction of the divisor from the current partial remainder; bit DATA_W is the borrow
    assign diff = {1'b0, work[2*DATA_W-1:DATA_W]} - {1'b0, dvs};

    // Quotient/remainder fixup: quotient sign from the operand XOR, remainder follows the dividend
    assign quo = neg_q ? -work[DATA_W-1:0] : work[DATA_W-1:0];
    assign rem = neg_r ? -work[2*DATA_W:DATA_W+1] : work[2*DATA_W:DATA_W+1];

    assign ready_o = (state == S_END);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_FREE;
        else
            state <= next;
    end

    // Next-state logic
    always_comb begin
        next = state;
        case (state)
            S_FREE:   next = take ? ((opdata2_i == '0) ? S_BYZERO : S_ON) : S_FREE;
            S_BYZERO: next = S_END;
            S_ON:     next = annul_i ? S_FREE : ((cnt == LAST) ? S_END : S_ON);
            S_END:    next = leave ? S_FREE : S_END;
            default:  next = S_FREE;
        endcase
    end

    // Datapath: operand capture, one quotient bit per cycle, result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            work     <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
        end else begin
            case (state)
                S_FREE: begin
                    result_o <= '0;
                    if (take) begin
                        cnt   <= '0;
                        work  <= {{DATA_W{1'b0}}, mag1, 1'b0};
                        dvs   <= mag2;
                        neg_q <= signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        neg_r <= signed_div_i && opdata1_i[DATA_W-1];
                    end
                end
                S_BYZERO: result_o <= '0;
                S_ON: begin
                    if (annul_i) begin
                        cnt      <= '0;
                        result_o <= '0;
                    end else if (cnt == LAST) begin
                        result_o <= {rem, quo};
                    end else begin
                        work <= diff[DATA_W] ? {work[2*DATA_W-1:0], 1'b0}
                                             : {diff[DATA_W-1:0], work[DATA_W-1:0], 1'b1};
                        cnt  <= cnt + 1'b1;
                    end
                end
                S_END: if (leave) result_o <= '0;
                default: result_o <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] opdata1 = '0;
    logic [31:0] opdata2 = '0;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic [63:0] result;
    logic        ready;
    int          errors = 0;
    int          checks = 0;

    div_unit #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one division from a negedge, wait (bounded) for ready, check latency/result/hold/clear.
    // With drop set, start falls and operands are scrambled after E3 to show they are ignored.
    task automatic run(input logic sg, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int lat, input bit drop, input string tag);
        int n;
        signed_div = sg; opdata1 = a; opdata2 = b; start = 1'b1; annul = 1'b0;
        n = 0;
        do begin
            @(posedge clk); n++; @(negedge clk);
            if (drop && n == 4) begin
                start = 1'b0; opdata1 = ~a; opdata2 = b + 32'd1;
            end
        end while (!ready && n < 40);
        chk({tag, " latency"}, 64'(n - 1), 64'(lat));
        chk({tag, " result"}, result, exp);
        if (!drop) begin
            repeat (2) begin @(posedge clk); @(negedge clk); end
            chk({tag, " hold ready"}, 64'(ready), 64'd1);
            chk({tag, " hold result"}, result, exp);
        end
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        chk({tag, " clear ready"}, 64'(ready), 64'd0);
        chk({tag, " clear result"}, result, 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("reset ready", 64'(ready), 64'd0);
        chk("reset result", result, 64'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        run(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1'b0, "u100/7");
        run(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33, 1'b0, "s-7/2");
        run(1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 1'b0, "s7/-2");
        run(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 1'b0, "smin/-1");
        run(1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 33, 1'b0, "u80000000/ffffffff");
        run(1'b0, 32'd5, 32'd0, 64'd0, 1, 1'b0, "div0");
        run(1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 33, 1'b1, "uffffffff/1 drop");

        // annul at iteration 10, then immediate restart
        signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3; start = 1'b1; annul = 1'b0;
        @(posedge clk);
        n = 0;
        repeat (10) begin
            @(posedge clk); @(negedge clk);
            if (ready) n++;
        end
        chk("annul pre ready", 64'(n), 64'd0);
        annul = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("annul ready", 64'(ready), 64'd0);
        chk("annul result", result, 64'd0);
        run(1'b0, 32'd20, 32'd3, 64'h00000002_00000006, 33, 1'b0, "annul restart 20/3");

        // start and annul together in FREE: ignored for 40 cycles
        signed_div = 1'b0; opdata1 = 32'd5; opdata2 = 32'd0; start = 1'b1; annul = 1'b1;
        n = 0;
        repeat (40) begin
            @(posedge clk); @(negedge clk);
            if (ready || result != 64'd0) n++;
        end
        chk("start+annul ignored", 64'(n), 64'd0);
        start = 1'b0; annul = 1'b0;
        @(negedge clk);

        // asynchronous reset at iteration 5
        opdata1 = 32'd1000; opdata2 = 32'd3; start = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midop reset ready", 64'(ready), 64'd0);
        chk("midop reset result", result, 64'd0);
        start = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        // asynchronous reset while a result is held
        opdata1 = 32'd8; opdata2 = 32'd2; start = 1'b1;
        n = 0;
        do begin @(posedge clk); n++; @(negedge clk); end while (!ready && n < 40);
        chk("8/2 result", result, 64'h00000000_00000004);
        #1 rst = 1'b1;
        #1;
        chk("end reset ready", 64'(ready), 64'd0);
        chk("end reset result", result, 64'd0);
        start = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        run(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 1'b0, "post-reset 9/3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
